// File: rtl/axi_err_slv_pkg.sv
// Default AXI channel and bundle types for the error slave.
package axi_err_slv_pkg;

  localparam int unsigned IdW   = 4;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 64;
  localparam int unsigned StrbW = DataW / 8;
  localparam int unsigned LenW  = 8;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [LenW-1:0]  len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       cache;
    logic [2:0]       prot;
  } ax_chan_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic [StrbW-1:0] strb;
    logic             last;
  } w_chan_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [1:0]     resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;

endpackage

// File: rtl/axi_err_slv_if.sv
// Request/response bundle between an upstream AXI stage and the error slave.
interface axi_err_slv_if;

  axi_err_slv_pkg::axi_req_t  req;
  axi_err_slv_pkg::axi_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);

endinterface

// File: rtl/axi_err_slv.sv
// Terminating AXI slave: sinks every write and read, answering each with a
// fixed error response. Write and read paths are independent FSMs.
module axi_err_slv #(
  parameter type         axi_req_t  = axi_err_slv_pkg::axi_req_t,
  parameter type         axi_resp_t = axi_err_slv_pkg::axi_resp_t,
  parameter logic [1:0]  RespCode   = 2'b11,
  parameter logic [63:0] RespData   = 64'hBADC_AB1E_DEAD_BEEF
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o
);

  localparam int unsigned IdW   = $bits(slv_req_i.aw.id);
  localparam int unsigned DataW = $bits(slv_resp_o.r.data);
  localparam int unsigned LenW  = 8;

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_DATA = 2'd1;
  localparam logic [1:0] WR_RESP = 2'd2;

  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_DATA = 1'b1;

  logic [1:0]      wr_state_q, wr_state_d;
  logic [IdW-1:0]  wid_q, wid_d;
  logic [0:0]      rd_state_q, rd_state_d;
  logic [IdW-1:0]  rid_q, rid_d;
  logic [LenW-1:0] len_q, len_d;
  logic [LenW-1:0] cnt_q, cnt_d;

  logic aw_ready_c, w_ready_c, b_valid_c;
  logic ar_ready_c, r_valid_c, r_last_c;

  // Address, data, strobe and attribute fields are deliberately discarded.
  logic unused_req;
  assign unused_req = ^slv_req_i;

  // Write path: accept AW, sink W beats up to last, then hold B until taken.
  always_comb begin
    wr_state_d = wr_state_q;
    wid_d      = wid_q;
    aw_ready_c = 1'b0;
    w_ready_c  = 1'b0;
    b_valid_c  = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        aw_ready_c = 1'b1;
        if (slv_req_i.aw_valid) begin
          wid_d      = slv_req_i.aw.id;
          wr_state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        w_ready_c = 1'b1;
        if (slv_req_i.w_valid && slv_req_i.w.last) begin
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        b_valid_c = 1'b1;
        if (slv_req_i.b_ready) begin
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= WR_IDLE;
      wid_q      <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wid_q      <= wid_d;
    end
  end

  // Read path: accept AR, then stream len+1 error beats; cnt_q stops at len_q.
  always_comb begin
    rd_state_d = rd_state_q;
    rid_d      = rid_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    ar_ready_c = 1'b0;
    r_valid_c  = 1'b0;
    r_last_c   = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        ar_ready_c = 1'b1;
        if (slv_req_i.ar_valid) begin
          rid_d      = slv_req_i.ar.id;
          len_d      = LenW'(slv_req_i.ar.len);
          cnt_d      = '0;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        r_valid_c = 1'b1;
        r_last_c  = (cnt_q == len_q);
        if (slv_req_i.r_ready) begin
          if (r_last_c) begin
            rd_state_d = RD_IDLE;
          end else begin
            cnt_d = cnt_q + LenW'(1);
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state_q <= RD_IDLE;
      rid_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rid_q      <= rid_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
    end
  end

  // Every output field is a decode of state or a register; unnamed fields stay 0.
  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_ready_c;
    slv_resp_o.w_ready  = w_ready_c;
    slv_resp_o.b_valid  = b_valid_c;
    slv_resp_o.b.id     = wid_q;
    slv_resp_o.b.resp   = RespCode;
    slv_resp_o.ar_ready = ar_ready_c;
    slv_resp_o.r_valid  = r_valid_c;
    slv_resp_o.r.id     = rid_q;
    slv_resp_o.r.data   = DataW'(RespData);
    slv_resp_o.r.resp   = RespCode;
    slv_resp_o.r.last   = r_last_c;
  end

  a_b_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (slv_resp_o.b_valid && !slv_req_i.b_ready) |=> $stable(slv_resp_o.b));

  a_r_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (slv_resp_o.r_valid && !slv_req_i.r_ready) |=> $stable(slv_resp_o.r));

  a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    (rd_state_q == RD_DATA) |-> (cnt_q <= len_q));

  a_aw_w_excl: assert property (@(posedge clk_i)
    !(slv_resp_o.aw_ready && slv_resp_o.w_ready));

  a_reset_quiet: assert property (@(posedge clk_i)
    rst_i |=> (!slv_resp_o.b_valid && !slv_resp_o.r_valid));

endmodule

// File: tb/tb_axi_err_slv.sv
// Bench for axi_err_slv: vector table of transactions plus hand-written
// corner sequences, with a scoreboard queue checking every B and R beat.
module tb_axi_err_slv;
  import axi_err_slv_pkg::*;

  localparam logic [63:0] RDATA = 64'hBADC_AB1E_DEAD_BEEF;
  localparam logic [1:0]  RCODE = 2'b11;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  axi_err_slv_if u_if ();

  axi_err_slv u_dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .slv_req_i  (u_if.req),
    .slv_resp_o (u_if.resp)
  );

  logic           aw_valid, w_valid, w_last, ar_valid, b_ready, r_ready;
  logic [IdW-1:0] aw_id, ar_id;
  logic [7:0]     ar_len;
  logic [63:0]    w_data;
  int             r_mode, b_mode;

  always_comb begin
    u_if.req          = '0;
    u_if.req.aw.id    = aw_id;
    u_if.req.aw.addr  = 32'h0000_1000;
    u_if.req.aw_valid = aw_valid;
    u_if.req.w.data   = w_data;
    u_if.req.w.strb   = '1;
    u_if.req.w.last   = w_last;
    u_if.req.w_valid  = w_valid;
    u_if.req.b_ready  = b_ready;
    u_if.req.ar.id    = ar_id;
    u_if.req.ar.len   = ar_len;
    u_if.req.ar_valid = ar_valid;
    u_if.req.r_ready  = r_ready;
  end

  function automatic logic pick(input int m);
    if (m == 0) return 1'b0;
    if (m == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  // Ready generators: 0 = held low, 1 = held high, 2 = random per cycle.
  always @(posedge clk) begin
    #2;
    r_ready = pick(r_mode);
    b_ready = pick(b_mode);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [IdW-1:0] id;
    logic           last;
  } r_exp_t;

  r_exp_t         rq[$];
  logic [IdW-1:0] bq[$];

  // Scoreboard: every handshake seen at the coming edge is compared here.
  always @(negedge clk) begin
    if (rst_i === 1'b0) begin
      if (u_if.resp.r_valid && u_if.req.r_ready) begin
        if (rq.size() == 0) begin
          chk("r_unexpected", 64'd1, 64'd0);
        end else begin
          r_exp_t e;
          e = rq.pop_front();
          chk("r_id", 64'(u_if.resp.r.id), 64'(e.id));
          chk("r_last", 64'(u_if.resp.r.last), 64'(e.last));
          chk("r_data", u_if.resp.r.data, RDATA);
          chk("r_resp", 64'(u_if.resp.r.resp), 64'(RCODE));
        end
      end
      if (u_if.resp.b_valid && u_if.req.b_ready) begin
        if (bq.size() == 0) begin
          chk("b_unexpected", 64'd1, 64'd0);
        end else begin
          logic [IdW-1:0] eid;
          eid = bq.pop_front();
          chk("b_id", 64'(u_if.resp.b.id), 64'(eid));
          chk("b_resp", 64'(u_if.resp.b.resp), 64'(RCODE));
        end
      end
    end
  end

  // ch: 0 = aw_ready, 1 = w_ready, 2 = ar_ready. Returns just after the handshake edge.
  task automatic wait_ready(input int ch, input string nm);
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clk);
      case (ch)
        0:       seen = u_if.resp.aw_ready;
        1:       seen = u_if.resp.w_ready;
        default: seen = u_if.resp.ar_ready;
      endcase
    end
    chk(nm, 64'(seen), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while ((rq.size() != 0 || bq.size() != 0) && n < 3000);
    chk("drain_done", 64'(rq.size() == 0 && bq.size() == 0), 64'd1);
    #1;
  endtask

  task automatic do_write(input logic [IdW-1:0] id, input logic [7:0] len,
                          input int mode, input int exp_cyc, input bit wait_b);
    int n;
    b_mode = mode;
    bq.push_back(id);
    aw_id    = id;
    aw_valid = 1'b1;
    wait_ready(0, "aw_hs");
    aw_valid = 1'b0;
    @(negedge clk);
    chk("w_ready_lat", 64'(u_if.resp.w_ready), 64'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i <= int'(len); i++) begin
      w_valid = 1'b1;
      w_last  = (i == int'(len));
      w_data  = {$urandom, $urandom};
      wait_ready(1, "w_hs");
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
    @(negedge clk);
    chk("b_valid_lat", 64'(u_if.resp.b_valid), 64'd1);
    chk("b_id_lat", 64'(u_if.resp.b.id), 64'(id));
    if (wait_b) begin
      drain(n);
      if (exp_cyc >= 0) chk("b_cycles", 64'(n), 64'(exp_cyc));
      @(negedge clk);
      chk("aw_ready_back", 64'(u_if.resp.aw_ready), 64'd1);
      chk("b_valid_clear", 64'(u_if.resp.b_valid), 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [IdW-1:0] id, input logic [7:0] len,
                         input int mode, input int exp_cyc);
    int n;
    r_exp_t e;
    r_mode = mode;
    for (int i = 0; i <= int'(len); i++) begin
      e.id   = id;
      e.last = (i == int'(len));
      rq.push_back(e);
    end
    ar_id    = id;
    ar_len   = len;
    ar_valid = 1'b1;
    wait_ready(2, "ar_hs");
    ar_valid = 1'b0;
    @(negedge clk);
    chk("r_valid_lat", 64'(u_if.resp.r_valid), 64'd1);
    drain(n);
    if (exp_cyc >= 0) chk("r_cycles", 64'(n), 64'(exp_cyc));
    @(negedge clk);
    chk("r_extra", 64'(u_if.resp.r_valid), 64'd0);
    chk("ar_ready_back", 64'(u_if.resp.ar_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit             is_wr;
    logic [IdW-1:0] id;
    logic [7:0]     len;
    int             mode;
    int             exp_cyc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int     n;
    r_exp_t e;

    vecs[0] = '{1'b1, 4'd5,  8'd0, 1,  1};
    vecs[1] = '{1'b1, 4'd9,  8'd3, 2, -1};
    vecs[2] = '{1'b0, 4'd3,  8'd3, 1,  4};
    vecs[3] = '{1'b0, 4'd15, 8'd0, 1,  1};
    vecs[4] = '{1'b0, 4'd1,  8'd7, 2, -1};
    vecs[5] = '{1'b1, 4'd0,  8'd1, 1,  1};

    rst_i = 1'b1;
    aw_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0; ar_valid = 1'b0;
    aw_id = '0; ar_id = '0; ar_len = '0; w_data = '0;
    r_mode = 1; b_mode = 1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_aw_ready", 64'(u_if.resp.aw_ready), 64'd1);
    chk("rst_ar_ready", 64'(u_if.resp.ar_ready), 64'd1);
    chk("rst_w_ready",  64'(u_if.resp.w_ready),  64'd0);
    chk("rst_b_valid",  64'(u_if.resp.b_valid),  64'd0);
    chk("rst_r_valid",  64'(u_if.resp.r_valid),  64'd0);
    chk("rst_b_id",     64'(u_if.resp.b.id),     64'd0);
    chk("rst_r_id",     64'(u_if.resp.r.id),     64'd0);
    chk("rst_r_last",   64'(u_if.resp.r.last),   64'd0);
    chk("rst_b_resp",   64'(u_if.resp.b.resp),   64'(RCODE));
    chk("rst_r_resp",   64'(u_if.resp.r.resp),   64'(RCODE));
    chk("rst_r_data",   u_if.resp.r.data,        RDATA);
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].id, vecs[i].len, vecs[i].mode, vecs[i].exp_cyc, 1'b1);
      else               do_read(vecs[i].id, vecs[i].len, vecs[i].mode, vecs[i].exp_cyc);
    end

    // Backpressure on a single-beat read: payload must hold for five cycles.
    r_mode = 0;
    e.id = 4'd6; e.last = 1'b1;
    rq.push_back(e);
    ar_id = 4'd6; ar_len = 8'd0; ar_valid = 1'b1;
    wait_ready(2, "bp_ar_hs");
    ar_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_r_valid", 64'(u_if.resp.r_valid), 64'd1);
      chk("bp_r_id",    64'(u_if.resp.r.id),    64'd6);
      chk("bp_r_last",  64'(u_if.resp.r.last),  64'd1);
      chk("bp_r_data",  u_if.resp.r.data,       RDATA);
    end
    @(posedge clk);
    #1;
    r_mode = 1;
    drain(n);
    chk("bp_cycles", 64'(n), 64'd1);
    @(negedge clk);
    chk("bp_r_extra", 64'(u_if.resp.r_valid), 64'd0);
    @(posedge clk);
    #1;

    // W ahead of AW while a 256-beat read streams.
    r_mode = 1; b_mode = 1;
    for (int i = 0; i < 256; i++) begin
      e.id = 4'd2; e.last = (i == 255);
      rq.push_back(e);
    end
    ar_id = 4'd2; ar_len = 8'd255; ar_valid = 1'b1;
    wait_ready(2, "long_ar_hs");
    ar_valid = 1'b0;
    bq.push_back(4'd7);
    w_valid = 1'b1; w_last = 1'b1; w_data = 64'h1234_5678_9ABC_DEF0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("w_stall", 64'(u_if.resp.w_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    aw_id = 4'd7; aw_valid = 1'b1;
    wait_ready(0, "wfirst_aw_hs");
    aw_valid = 1'b0;
    wait_ready(1, "wfirst_w_hs");
    w_valid = 1'b0; w_last = 1'b0;
    drain(n);
    @(negedge clk);
    chk("long_r_extra", 64'(u_if.resp.r_valid), 64'd0);
    chk("wfirst_b_clear", 64'(u_if.resp.b_valid), 64'd0);
    @(posedge clk);
    #1;

    // Reset during beat 2 of a len=7 read with a B pending.
    do_write(4'd4, 8'd0, 0, -1, 1'b0);
    r_mode = 1;
    for (int i = 0; i < 8; i++) begin
      e.id = 4'd10; e.last = (i == 7);
      rq.push_back(e);
    end
    ar_id = 4'd10; ar_len = 8'd7; ar_valid = 1'b1;
    wait_ready(2, "rst_ar_hs");
    ar_valid = 1'b0;
    @(negedge clk);
    chk("mid_r_valid", 64'(u_if.resp.r_valid), 64'd1);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_r_valid",  64'(u_if.resp.r_valid),  64'd0);
    chk("mid_rst_b_valid",  64'(u_if.resp.b_valid),  64'd0);
    chk("mid_rst_aw_ready", 64'(u_if.resp.aw_ready), 64'd1);
    chk("mid_rst_ar_ready", 64'(u_if.resp.ar_ready), 64'd1);
    chk("mid_rst_b_id",     64'(u_if.resp.b.id),     64'd0);
    chk("mid_rst_r_id",     64'(u_if.resp.r.id),     64'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    rq.delete();
    bq.delete();
    b_mode = 1;
    r_mode = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_r_valid", 64'(u_if.resp.r_valid), 64'd0);
      chk("post_rst_b_valid", 64'(u_if.resp.b_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    do_write(4'd11, 8'd2, 1, 1, 1'b1);
    do_read(4'd12, 8'd1, 1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

endmodule
